brick_field_ctrl: RTL and testbench
===================================

# brick_field_ctrl

Owns the 1440-bit brick field register that feeds `ball_control`, and commits the `next_bricks` it returns each `clk_22` tick. It loads the per-level brick pattern row by row and accumulates a 4-digit BCD score from `collision_trig`. It also tracks lives and level, detects level clear and game over, and issues one-cycle `skill` grant pulses that `ball_control` ORs into its `skill_remain`.

## Interface
- `ROWS_FILLED`, 8, number of brick rows loaded, starting at row 2 (rows 2..9).
- `NUM_LEVELS`, 4, levels before `level` wraps to 0.
- `HITS_PER_SKILL`, 8, hit cycles between skill grants.
- `clk_22`  in  1  game tick clock.
- `rst`  in  1  asynchronous, active-high reset.
- `state`  in  3  top-level game state; 3 = PLAY.
- `start_level`  in  1  one-cycle pulse from the menu FSM.
- `ball_lost`  in  1  one-cycle pulse when the ball falls below V+50.
- `next_bricks`  in  1440  field proposed by `ball_control`.
- `collision_trig`  in  4  sum of hit brick values this tick, binary 0..15.
- `bricks`  out  1440  committed field. Cell idx = col + 20*row (col 0..19, row 0..23), bits [3*idx+:3]; 0 = empty, 1..7 = brick type.
- `score`  out  16  4-digit BCD; [15:12] is thousands.
- `lives`  out  2  remaining balls.
- `level`  out  2  current level.
- `level_clear`  out  1  one-cycle pulse.
- `game_over`  out  1  level signal, high in OVER.
- `loading`  out  1  high in LOAD.
- `skill`  out  3  one-hot one-cycle grant pulse; 0 otherwise.

## Operation
- FSM states: IDLE, LOAD, RUN, CLEAR, OVER.
- IDLE:
  - `start_level` -> LOAD.
  - Score and lives are not touched; they are valid from reset.
- LOAD:
  - `row_cnt` runs 0..23, one row written per cycle, all 20 cells of the row.
  - Rows 2..2+ROWS_FILLED-1 get cell value ((row + col + level) mod 7) + 1; all other rows get 0.
  - After row 23 is written -> RUN, `row_cnt` returns to 0.
  - `next_bricks` is ignored during LOAD.
- RUN:
  - If `state`==3, then `bricks` <= `next_bricks`.
  - If `state`!=3, `bricks`, score, the hit counter and the skill logic all hold.
  - Score: when `state`==3 and `collision_trig`!=0, add `collision_trig` to `score`. Convert it to BCD tens/ones, then do a 4-digit BCD add with carry. If the result exceeds 9999, saturate at 16'h9999.
  - Hit counter (0..HITS_PER_SKILL-1) increments on each such cycle. On wrap it pulses `skill` with the rotor value, then rotates the rotor 001->010->100->001.
  - `ball_lost`:
    - If `lives`>1, `lives` decrements.
    - If `lives`==1, `lives` goes to 0 -> OVER.
  - Level clear: committed `bricks`==0 -> pulse `level_clear`, go to CLEAR.
  - `start_level` is ignored in RUN.
- CLEAR:
  - `start_level` sets `level` <= (level+1) mod NUM_LEVELS, then -> LOAD.
  - Score and lives are kept.
- OVER:
  - `game_over`=1.
  - `start_level` sets score=0, lives=3, level=0, hit counter=0, rotor=001, then -> LOAD.
- Simultaneous events:
  - Level clear and `ball_lost` in the same cycle: clear wins, the life is not deducted.
  - Score add and skill pulse in the same cycle as clear: both still happen.

## Timing
- Reset values: `bricks`=0, `score`=0, `lives`=3, `level`=0, `level_clear`=0, `game_over`=0, `loading`=0, `skill`=0, FSM=IDLE, rotor=001.
- `rst` asserted mid-LOAD or mid-RUN returns everything to the reset values immediately.
- `start_level` sampled at edge k -> LOAD from k+1. Rows 0..23 are written at edges k+1..k+24; RUN from k+25. `loading` is high for exactly 24 cycles.
- `bricks` commit, score, `lives`, and `skill`: registered, one cycle after the inputs are sampled.
- Clear check uses the registered `bricks`. `level_clear` is asserted on the edge after the field became 0 and is high for exactly 1 cycle.
- `skill` is high for exactly 1 cycle per grant.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then pulse `start_level` -> `loading` high 24 cycles. Then bits [120+:3]=3 (row 2, col 0) and [3*(19+180)+:3]=((9+19)%7)+1=1. Rows 0,1 and 10..23 are all 0.
- RUN with `state`=3, `collision_trig`=7 for 3 cycles, score preset to 16'h0995 -> `score` ends at 16'h1016. Then preset 16'h9990 and add 15 -> `score` 16'h9999 (saturated).
- Drive 8 cycles with `collision_trig`=1 -> `skill`=001 pulses once. 8 more -> 010; 8 more -> 100; 8 more -> 001.
- `state`=0 while `next_bricks` differs -> `bricks`, `score` and `skill` unchanged.
- Three `ball_lost` pulses -> `lives` 3,2,1,0 with `game_over`=1 in OVER. Then `start_level` -> score 0, lives 3, level 0, reload.
- Drive `next_bricks`=0 together with `ball_lost` -> one `level_clear` pulse, `lives` unchanged. Then `start_level` -> level 1, and cell (row 2, col 0) reloads as 4.

Source files
------------

// File: rtl/brick_field_ctrl.sv
// rtl/brick_field_ctrl.sv - brick field owner, level loader, BCD score, lives/level and skill grants
//
// Holds the committed 1440-bit brick field, loads the per-level pattern one
// row per tick, accumulates a saturating 4-digit BCD score, tracks lives and
// level, and emits one-cycle level_clear and skill grant pulses.
//
// Ports:
//   clk_22          game tick clock
//   rst             asynchronous, active-high reset
//   state[2:0]      top-level game state (3 = PLAY)
//   start_level     one-cycle pulse from the menu FSM
//   ball_lost       one-cycle pulse when the ball is lost
//   next_bricks     field proposed by ball_control
//   collision_trig  binary sum of hit brick values this tick (0..15)
//   bricks          committed field, cell idx = col + 20*row, bits [3*idx+:3]
//   score[15:0]     4-digit BCD score
//   lives[1:0]      remaining balls
//   level[1:0]      current level
//   level_clear     one-cycle pulse when the committed field empties
//   game_over       high while in OVER
//   loading         high while the pattern is being written
//   skill[2:0]      one-hot one-cycle skill grant

module brick_field_ctrl #(
    parameter int ROWS_FILLED    = 8,
    parameter int NUM_LEVELS     = 4,
    parameter int HITS_PER_SKILL = 8
) (
    input  logic            clk_22,
    input  logic            rst,
    input  logic [2:0]      state,
    input  logic            start_level,
    input  logic            ball_lost,
    input  logic [1439:0]   next_bricks,
    input  logic [3:0]      collision_trig,
    output logic [1439:0]   bricks,
    output logic [15:0]     score,
    output logic [1:0]      lives,
    output logic [1:0]      level,
    output logic            level_clear,
    output logic            game_over,
    output logic            loading,
    output logic [2:0]      skill
);

    localparam int         HIT_W    = (HITS_PER_SKILL > 1) ? $clog2(HITS_PER_SKILL) : 1;
    localparam logic [2:0] PLAY     = 3'd3;
    localparam logic [4:0] LAST_ROW = 5'd23;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_CLEAR,
        S_OVER
    } fsm_t;

    fsm_t             fsm;
    logic [4:0]       row_cnt;
    logic [HIT_W-1:0] hit_cnt;
    logic [2:0]       rotor;

    logic [59:0]      row_data;
    logic [10:0]      row_base;
    logic [16:0]      score_sum;
    logic             play_hit;

    // Pattern value for one cell; rows outside the filled band are empty.
    function automatic logic [2:0] cell_value(input logic [4:0] row,
                                              input logic [4:0] col,
                                              input logic [1:0] lvl);
        logic [5:0] s;
        logic [2:0] m;
        s = {1'b0, row} + {1'b0, col} + {4'b0, lvl};
        m = 3'(s % 6'd7);
        if (int'(row) >= 2 && int'(row) < 2 + ROWS_FILLED)
            return m + 3'd1;
        return 3'd0;
    endfunction

    // Adds a binary 0..15 value to a 4-digit BCD number.
    // Bit 16 of the result is the carry out of the thousands digit.
    function automatic logic [16:0] bcd_add(input logic [15:0] a,
                                            input logic [3:0]  bin);
        logic [15:0] b;
        logic [15:0] r;
        logic [4:0]  s;
        logic        c;
        b = (bin >= 4'd10) ? {8'h00, 4'd1, bin - 4'd10} : {12'h000, bin};
        r = '0;
        c = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s = {1'b0, a[4*i+:4]} + {1'b0, b[4*i+:4]} + {4'b0, c};
            if (s > 5'd9) begin
                s = s - 5'd10;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            r[4*i+:4] = s[3:0];
        end
        return {c, r};
    endfunction

    always_comb begin
        row_data = '0;
        for (int c = 0; c < 20; c++)
            row_data[3*c+:3] = cell_value(row_cnt, 5'(c), level);
    end

    assign row_base  = 11'(row_cnt) * 11'd60;
    assign score_sum = bcd_add(score, collision_trig);
    assign play_hit  = (state == PLAY) && (collision_trig != 4'd0);

    always_ff @(posedge clk_22 or posedge rst) begin
        if (rst) begin
            fsm         <= S_IDLE;
            row_cnt     <= '0;
            hit_cnt     <= '0;
            rotor       <= 3'b001;
            bricks      <= '0;
            score       <= '0;
            lives       <= 2'd3;
            level       <= '0;
            level_clear <= 1'b0;
            game_over   <= 1'b0;
            loading     <= 1'b0;
            skill       <= '0;
        end else begin
            level_clear <= 1'b0;
            skill       <= '0;

            case (fsm)
                S_IDLE: begin
                    if (start_level) begin
                        fsm     <= S_LOAD;
                        loading <= 1'b1;
                        row_cnt <= '0;
                    end
                end

                S_LOAD: begin
                    bricks[row_base +: 60] <= row_data;
                    if (row_cnt == LAST_ROW) begin
                        fsm     <= S_RUN;
                        loading <= 1'b0;
                        row_cnt <= '0;
                    end else begin
                        row_cnt <= row_cnt + 5'd1;
                    end
                end

                S_RUN: begin
                    if (state == PLAY)
                        bricks <= next_bricks;

                    if (play_hit) begin
                        score <= score_sum[16] ? 16'h9999 : score_sum[15:0];
                        if (hit_cnt == HIT_W'(HITS_PER_SKILL - 1)) begin
                            hit_cnt <= '0;
                            skill   <= rotor;
                            rotor   <= {rotor[1:0], rotor[2]};
                        end else begin
                            hit_cnt <= hit_cnt + HIT_W'(1);
                        end
                    end

                    // An empty committed field outranks a lost ball in the same tick.
                    if (bricks == '0) begin
                        level_clear <= 1'b1;
                        fsm         <= S_CLEAR;
                    end else if (ball_lost) begin
                        if (lives > 2'd1) begin
                            lives <= lives - 2'd1;
                        end else begin
                            lives     <= 2'd0;
                            fsm       <= S_OVER;
                            game_over <= 1'b1;
                        end
                    end
                end

                S_CLEAR: begin
                    if (start_level) begin
                        level   <= (level == 2'(NUM_LEVELS - 1)) ? 2'd0 : level + 2'd1;
                        fsm     <= S_LOAD;
                        loading <= 1'b1;
                        row_cnt <= '0;
                    end
                end

                S_OVER: begin
                    if (start_level) begin
                        score     <= '0;
                        lives     <= 2'd3;
                        level     <= '0;
                        hit_cnt   <= '0;
                        rotor     <= 3'b001;
                        game_over <= 1'b0;
                        fsm       <= S_LOAD;
                        loading   <= 1'b1;
                        row_cnt   <= '0;
                    end
                end

                default: begin
                    fsm <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_brick_field_ctrl.sv
// tb/tb_brick_field_ctrl.sv - scoreboard bench for brick_field_ctrl

module tb_brick_field_ctrl;

    logic          clk_22 = 1'b0;
    logic          rst = 1'b1;
    logic [2:0]    state = 3'd0;
    logic          start_level = 1'b0;
    logic          ball_lost = 1'b0;
    logic [1439:0] next_bricks = '0;
    logic [3:0]    collision_trig = 4'd0;

    logic [1439:0] bricks;
    logic [15:0]   score;
    logic [1:0]    lives;
    logic [1:0]    level;
    logic          level_clear;
    logic          game_over;
    logic          loading;
    logic [2:0]    skill;

    brick_field_ctrl #(
        .ROWS_FILLED    (8),
        .NUM_LEVELS     (4),
        .HITS_PER_SKILL (8)
    ) dut (
        .clk_22         (clk_22),
        .rst            (rst),
        .state          (state),
        .start_level    (start_level),
        .ball_lost      (ball_lost),
        .next_bricks    (next_bricks),
        .collision_trig (collision_trig),
        .bricks         (bricks),
        .score          (score),
        .lives          (lives),
        .level          (level),
        .level_clear    (level_clear),
        .game_over      (game_over),
        .loading        (loading),
        .skill          (skill)
    );

    always #5 clk_22 = ~clk_22;

    int n_vec = 0;
    int n_err = 0;

    localparam int M_IDLE  = 0;
    localparam int M_LOAD  = 1;
    localparam int M_RUN   = 2;
    localparam int M_CLEAR = 3;
    localparam int M_OVER  = 4;

    int            m_st, m_row, m_score, m_lives, m_level, m_hit;
    logic [2:0]    m_rot, m_skill;
    logic          m_clr;
    logic [1439:0] m_bricks;

    typedef struct {
        logic [15:0] score;
        logic [1:0]  lives;
        logic [1:0]  level;
        logic [2:0]  skill;
        logic        clr;
        logic        over;
        logic        load;
        logic [63:0] fold;
    } exp_t;

    exp_t sb_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [2:0] exp_cell(input int r, input int c, input int lvl);
        if (r >= 2 && r <= 9)
            return 3'(((r + c + lvl) % 7) + 1);
        return 3'd0;
    endfunction

    function automatic logic [63:0] fold64(input logic [1439:0] v);
        logic [1471:0] p;
        logic [63:0]   f;
        p = {32'b0, v};
        f = '0;
        for (int i = 0; i < 23; i++)
            f ^= p[64*i+:64];
        return f;
    endfunction

    task automatic model_reset();
        m_st     = M_IDLE;
        m_row    = 0;
        m_bricks = '0;
        m_score  = 0;
        m_lives  = 3;
        m_level  = 0;
        m_hit    = 0;
        m_rot    = 3'b001;
        m_skill  = 3'b000;
        m_clr    = 1'b0;
    endtask

    task automatic model_step();
        bit fz;
        fz      = (m_bricks == '0);
        m_clr   = 1'b0;
        m_skill = 3'b000;
        case (m_st)
            M_IDLE: begin
                if (start_level) begin
                    m_st  = M_LOAD;
                    m_row = 0;
                end
            end
            M_LOAD: begin
                for (int c = 0; c < 20; c++)
                    m_bricks[3*(c + 20*m_row)+:3] = exp_cell(m_row, c, m_level);
                if (m_row == 23) begin
                    m_st  = M_RUN;
                    m_row = 0;
                end else begin
                    m_row++;
                end
            end
            M_RUN: begin
                if (state == 3'd3) begin
                    m_bricks = next_bricks;
                    if (collision_trig != 4'd0) begin
                        m_score += int'(collision_trig);
                        if (m_score > 9999) m_score = 9999;
                        m_hit++;
                        if (m_hit == 8) begin
                            m_hit   = 0;
                            m_skill = m_rot;
                            m_rot   = (m_rot == 3'b100) ? 3'b001 : (m_rot << 1);
                        end
                    end
                end
                if (fz) begin
                    m_clr = 1'b1;
                    m_st  = M_CLEAR;
                end else if (ball_lost) begin
                    if (m_lives > 1) begin
                        m_lives--;
                    end else begin
                        m_lives = 0;
                        m_st    = M_OVER;
                    end
                end
            end
            M_CLEAR: begin
                if (start_level) begin
                    m_level = (m_level + 1) % 4;
                    m_st    = M_LOAD;
                    m_row   = 0;
                end
            end
            M_OVER: begin
                if (start_level) begin
                    m_score = 0;
                    m_lives = 3;
                    m_level = 0;
                    m_hit   = 0;
                    m_rot   = 3'b001;
                    m_st    = M_LOAD;
                    m_row   = 0;
                end
            end
            default: ;
        endcase
    endtask

    task automatic push_exp();
        exp_t e;
        e.score = to_bcd(m_score);
        e.lives = 2'(m_lives);
        e.level = 2'(m_level);
        e.skill = m_skill;
        e.clr   = m_clr;
        e.over  = (m_st == M_OVER);
        e.load  = (m_st == M_LOAD);
        e.fold  = fold64(m_bricks);
        sb_q.push_back(e);
    endtask

    task automatic compare_all();
        exp_t e;
        e = sb_q.pop_front();
        check("score",       score,        e.score);
        check("lives",       lives,        e.lives);
        check("level",       level,        e.level);
        check("skill",       skill,        e.skill);
        check("level_clear", level_clear,  e.clr);
        check("game_over",   game_over,    e.over);
        check("loading",     loading,      e.load);
        check("bricks_fold", fold64(bricks), e.fold);
    endtask

    // One clock: model predicts, expectation queued, DUT sampled 1 ns after the edge.
    task automatic step();
        model_step();
        push_exp();
        @(posedge clk_22);
        #1;
        compare_all();
    endtask

    task automatic rand_field();
        for (int i = 0; i < 45; i++)
            next_bricks[32*i+:32] = $urandom;
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b1;
        model_reset();
        push_exp();
        #1;
        compare_all();
        @(negedge clk_22);
        rst = 1'b0;
    endtask

    task automatic load_level();
        int cnt;
        start_level = 1'b1;
        step();
        start_level = 1'b0;
        cnt = loading ? 1 : 0;
        for (int i = 0; i < 24; i++) begin
            rand_field();
            step();
            if (loading) cnt++;
        end
        check("loading_cycles", cnt, 24);
    endtask

    task automatic check_pattern(input logic [2:0] c_r2c0, input logic [2:0] c_r9c19);
        check("cell_r2c0",  bricks[120+:3],        c_r2c0);
        check("cell_r9c19", bricks[3*(19+180)+:3], c_r9c19);
        for (int r = 0; r < 24; r++)
            if (r < 2 || r > 9)
                check("row_empty", bricks[60*r+:60], 60'd0);
    endtask

    task automatic add_to(input int target);
        int d;
        state = 3'd3;
        while (m_score < target) begin
            d = target - m_score;
            collision_trig = (d > 15) ? 4'd15 : 4'(d);
            next_bricks = m_bricks;
            step();
        end
        collision_trig = 4'd0;
    endtask

    initial begin
        logic [63:0] fold_before;
        logic [15:0] score_before;
        logic [2:0]  exp_seq [4];
        int          pulses;

        exp_seq[0] = 3'b001;
        exp_seq[1] = 3'b010;
        exp_seq[2] = 3'b100;
        exp_seq[3] = 3'b001;

        // Reset values
        model_reset();
        @(posedge clk_22);
        @(posedge clk_22);
        #1;
        push_exp();
        compare_all();
        @(negedge clk_22);
        rst = 1'b0;

        step();
        step();

        // First level load, next_bricks is random garbage throughout
        load_level();
        check_pattern(3'd3, 3'd1);

        // Score: reach 0995, add 7 three times
        add_to(995);
        check("score_preset", score, 16'h0995);
        state = 3'd3;
        collision_trig = 4'd7;
        for (int i = 0; i < 3; i++) begin
            next_bricks = m_bricks;
            step();
        end
        check("score_1016", score, 16'h1016);

        // Saturation
        add_to(9990);
        check("score_9990", score, 16'h9990);
        collision_trig = 4'd15;
        next_bricks = m_bricks;
        step();
        check("score_sat", score, 16'h9999);
        step();
        check("score_sat_hold", score, 16'h9999);
        collision_trig = 4'd0;

        // Not in PLAY: everything holds despite a different proposed field and hits
        fold_before  = fold64(m_bricks);
        score_before = to_bcd(m_score);
        state = 3'd0;
        collision_trig = 4'd5;
        for (int i = 0; i < 3; i++) begin
            rand_field();
            step();
            check("hold_skill", skill, 3'b000);
        end
        check("hold_bricks", fold64(bricks), fold_before);
        check("hold_score",  score,          score_before);
        collision_trig = 4'd0;

        // Three lost balls -> OVER
        state = 3'd3;
        for (int i = 0; i < 3; i++) begin
            next_bricks = m_bricks;
            ball_lost = 1'b1;
            step();
            ball_lost = 1'b0;
            check("lives_lost", lives, 64'(2 - i));
            step();
        end
        check("game_over_set", game_over, 1'b1);

        // Restart from OVER
        load_level();
        check("restart_score", score, 16'h0000);
        check("restart_lives", lives, 2'd3);
        check("restart_level", level, 2'd0);
        check_pattern(3'd3, 3'd1);

        // Skill rotor: 32 single-point hits
        state = 3'd3;
        collision_trig = 4'd1;
        pulses = 0;
        for (int i = 0; i < 32; i++) begin
            next_bricks = m_bricks;
            step();
            if (skill != 3'b000) pulses++;
            if (i % 8 == 7)
                check("skill_grant", skill, exp_seq[i/8]);
        end
        check("skill_pulses", pulses, 4);
        collision_trig = 4'd0;

        // Level clear coinciding with ball_lost and a score add
        next_bricks = '0;
        step();
        ball_lost = 1'b1;
        collision_trig = 4'd3;
        step();
        check("clear_pulse", level_clear, 1'b1);
        check("clear_lives", lives, 2'd3);
        check("clear_score", score, 16'h0035);
        ball_lost = 1'b0;
        collision_trig = 4'd0;
        step();
        check("clear_one_cycle", level_clear, 1'b0);

        load_level();
        check("level_next", level, 2'd1);
        check_pattern(3'd4, 3'd2);

        // Asynchronous reset mid-RUN
        state = 3'd3;
        collision_trig = 4'd2;
        for (int i = 0; i < 3; i++) begin
            next_bricks = m_bricks;
            step();
        end
        collision_trig = 4'd0;
        async_reset();
        check("rst_run_lives", lives, 2'd3);

        // Asynchronous reset mid-LOAD
        start_level = 1'b1;
        step();
        start_level = 1'b0;
        for (int i = 0; i < 10; i++)
            step();
        async_reset();
        check("rst_load_loading", loading, 1'b0);

        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
